display_frame_store: RTL and testbench
======================================

Name: display_frame_store

Overview:
Double-buffered frame store feeding the 74595 row-scan driver. The host writes rows into the back buffer. A swap request takes effect only at a frame boundary, so the scan driver never shows a torn frame. An optional tick-driven auto-update engine animates the displayed frame: shift-down-and-increment, rotate, or invert. The scan driver reads the front buffer one row at a time through a registered read port.

Parameters:
ROWS, 4, number of display rows (power of two, >=2)
COLS, 8, bits per row (one bit per 74595 output)
ROW_W, $clog2(ROWS), row index width (derived; do not override)

Ports:
CLK  in  1  system clock, all logic on posedge
RST  in  1  asynchronous active-high reset
wr_en  in  1  write strobe; wr_data stored to back buffer row wr_row
wr_row  in  ROW_W  write row index
wr_data  in  COLS  write data
swap_req  in  1  single-cycle pulse; request front/back swap
swap_pending  out  1  high from the cycle after swap_req until the swap executes
frame_start  in  1  pulse from scan driver when row 0 is committed (frame boundary)
rd_row  in  ROW_W  front-buffer row requested by scan driver
rd_data  out  COLS  registered front-buffer row data
tick  in  1  auto-update strobe (e.g. prescaler bit edge)
auto_en  in  1  enable auto-update engine
mode  in  2  00 hold, 01 shift+inc, 10 rotate-left, 11 invert

Behaviour:
- Reset (async, RST=1): both buffers all-zero; front select=0; swap_pending=0; tick_pending=0; rd_data=0.
- Read: rd_data <= front[rd_row] every cycle. Latency is 1 cycle. A swap or auto-update at edge N is visible in rd_data from edge N+1 onward.
- Write: when wr_en=1, back[wr_row] <= wr_data. Writes are always accepted and never stall. Writing the same row twice in a row is last-wins.
- Swap FSM, states IDLE and PENDING:
  - IDLE: swap_req -> PENDING.
  - PENDING: frame_start -> toggle front select, return to IDLE.
  - swap_req and frame_start in the same cycle while in IDLE: go to PENDING only. The swap executes at the next frame_start (no same-cycle swap).
  - swap_req while already PENDING is ignored (no queueing).
  - swap_pending = (state == PENDING).
- Write in the cycle the swap executes: the data goes to the pre-swap back buffer and becomes visible in the new front. The write is never lost.
- Auto-update:
  - tick=1 sets tick_pending.
  - At frame_start with tick_pending=1 and auto_en=1, transform the front buffer in one cycle and clear tick_pending.
  - mode 01: front[r] <= front[r-1] for r>=1; front[0] <= front[0]+1, mod 2^COLS (255 wraps to 0 for COLS=8).
  - mode 10: each row rotated left by 1 (MSB moves to LSB).
  - mode 11: each row bitwise inverted.
  - mode 00: no change, but tick_pending is still cleared.
  - auto_en=0: tick_pending is held, not cleared.
- Simultaneous swap execution and auto-update at one frame_start: the swap takes priority. tick_pending stays set and the update applies at the next frame_start, to the new front.
- tick and frame_start in the same cycle: tick_pending is set, and the update waits for the next frame_start.
- Front select is a single bit; the buffers are ROWS x COLS register arrays (no RAM inference required).

Optional Feature:
- Macro: FRAME_STORE_COPY_ON_SWAP_EN.
- Defined: in the swap cycle, the new back buffer (old front) is loaded with a copy of the new front contents, so the host can make incremental edits.
  - Any wr_en in that cycle is applied to the new front, and that row is also copied with the written value.
- Not defined: the new back buffer keeps its stale contents (the old front).

Test Plan:
- Reset, then sweep rd_row 0..3 -> rd_data=0x00 on every row; swap_pending=0.
- Write rows 0..3 = 0x11,0x22,0x44,0x88; pulse swap_req; no frame_start -> rd_data still 0, swap_pending=1. Pulse frame_start -> swap_pending=0 and next cycle rd_row=2 gives 0x44.
- swap_req and frame_start in the same cycle -> no swap and swap_pending=1. Next frame_start -> swap executes.
- mode=01, auto_en=1, front row0=0xFF, rows1..3=0: tick then frame_start -> row0=0x00, row1=0xFF. Repeat -> row0=0x01, row1=0x00, row2=0xFF.
- mode=10, front row0=0x81: tick+frame_start -> 0x03. Then mode=11 -> 0xFC. auto_en=0 with tick pending -> no change until auto_en=1 and frame_start.
- Swap pending plus tick pending at one frame_start -> swap only. Following frame_start -> transform applied to the new front. Assert RST mid-PENDING -> all outputs are 0 immediately (async).

Source files
------------

// File: rtl/display_frame_store.sv
// Double-buffered frame store for the 74595 row-scan driver.
// The host writes the back buffer. A swap takes effect only at a frame boundary, and an
// optional tick-driven engine animates the front buffer. The scan driver reads the front
// buffer through a registered read port.
// Optional feature macro: FRAME_STORE_COPY_ON_SWAP_EN. When it is defined, the swap also
// loads the new back buffer with a copy of the new front, so host edits can be incremental.
module display_frame_store #(
  parameter int ROWS  = 4,
  parameter int COLS  = 8,
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COLS-1:0]  wr_data,
  input  logic             swap_req,
  output logic             swap_pending,
  input  logic             frame_start,
  input  logic [ROW_W-1:0] rd_row,
  output logic [COLS-1:0]  rd_data,
  input  logic             tick,
  input  logic             auto_en,
  input  logic [1:0]       mode
);

  typedef enum logic {StIdle, StPending} swap_st_e;
  typedef logic [ROWS-1:0][COLS-1:0] frame_t;

  swap_st_e        state_q;
  logic            front_sel_q;
  frame_t          buf0_q, buf0_d;
  frame_t          buf1_q, buf1_d;
  logic            tick_pending_q, tick_pending_d;
  logic [COLS-1:0] rd_data_q;

  frame_t front_cur, back_cur;
  frame_t front_new, back_new;
  logic   swap_exec;
  logic   upd_exec;

  // A swap beats an auto-update at the same frame boundary; the update waits one frame.
  assign swap_exec = (state_q == StPending) && frame_start;
  assign upd_exec  = frame_start && tick_pending_q && auto_en && !swap_exec;

  // Next contents of both buffers: host write into back, optional transform of front.
  always_comb begin
    front_cur = front_sel_q ? buf1_q : buf0_q;
    back_cur  = front_sel_q ? buf0_q : buf1_q;

    back_new = back_cur;
    if (wr_en) begin
      back_new[wr_row] = wr_data;
    end

    front_new = front_cur;
    if (upd_exec) begin
      unique case (mode)
        2'b01: begin
          for (int r = 1; r < ROWS; r++) begin
            front_new[ROW_W'(r)] = front_cur[ROW_W'(r - 1)];
          end
          front_new[0] = front_cur[0] + COLS'(1);
        end
        2'b10: begin
          for (int r = 0; r < ROWS; r++) begin
            front_new[ROW_W'(r)] = {front_cur[ROW_W'(r)][COLS-2:0],
                                    front_cur[ROW_W'(r)][COLS-1]};
          end
        end
        2'b11: begin
          for (int r = 0; r < ROWS; r++) begin
            front_new[ROW_W'(r)] = ~front_cur[ROW_W'(r)];
          end
        end
        default: begin
          front_new = front_cur;
        end
      endcase
    end

    buf0_d = front_sel_q ? back_new : front_new;
    buf1_d = front_sel_q ? front_new : back_new;
`ifdef FRAME_STORE_COPY_ON_SWAP_EN
    // The old front becomes the new back and takes the new front image, including any
    // write landing in this cycle.
    if (swap_exec) begin
      buf0_d = back_new;
      buf1_d = back_new;
    end
`endif

    // A tick in the same cycle as an update re-arms the engine for the next frame.
    tick_pending_d = tick | (tick_pending_q & ~upd_exec);
  end

  // Swap FSM: arm on swap_req, flip the front select at the next frame boundary.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      front_sel_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (swap_req) begin
            state_q <= StPending;
          end
        end
        StPending: begin
          if (frame_start) begin
            front_sel_q <= ~front_sel_q;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Buffer storage, tick latch and the registered scan read port.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buf0_q         <= '0;
      buf1_q         <= '0;
      tick_pending_q <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      buf0_q         <= buf0_d;
      buf1_q         <= buf1_d;
      tick_pending_q <= tick_pending_d;
      rd_data_q      <= front_cur[rd_row];
    end
  end

  assign rd_data      = rd_data_q;
  assign swap_pending = (state_q == StPending);

endmodule

// File: tb/tb_display_frame_store.sv
// Scoreboard bench for display_frame_store: stimulus queues the expected read results and
// a monitor compares rd_data and swap_pending on the cycle each read is presented.
module tb_display_frame_store;

  localparam int ROWS  = 4;
  localparam int COLS  = 8;
  localparam int ROW_W = 2;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             wr_en = 1'b0;
  logic [ROW_W-1:0] wr_row = '0;
  logic [COLS-1:0]  wr_data = '0;
  logic             swap_req = 1'b0;
  logic             swap_pending;
  logic             frame_start = 1'b0;
  logic [ROW_W-1:0] rd_row = '0;
  logic [COLS-1:0]  rd_data;
  logic             tick = 1'b0;
  logic             auto_en = 1'b0;
  logic [1:0]       mode = 2'b00;

  typedef struct {
    int              id;
    logic [COLS-1:0] data;
    logic            sp;
  } exp_t;

  exp_t exp_q[$];
  logic chk_valid = 1'b0;
  int   chk_id = 0;
  int   checks = 0;
  int   failures = 0;

  display_frame_store #(.ROWS(ROWS), .COLS(COLS)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .frame_start  (frame_start),
    .rd_row       (rd_row),
    .rd_data      (rd_data),
    .tick         (tick),
    .auto_en      (auto_en),
    .mode         (mode)
  );

  always #5 CLK = ~CLK;

  // Monitor: a read presented in a cycle shows up on rd_data just after that edge.
  always @(posedge CLK) begin
    if (chk_valid) begin
      exp_t e;
      #1;
      if (exp_q.size() == 0) begin
        failures++;
        checks++;
        $display("FAIL rd_chk: scoreboard empty, rd_data=%02h", rd_data);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e.data) begin
          failures++;
          $display("FAIL rd_data#%0d: got %02h expected %02h", e.id, rd_data, e.data);
        end
        checks++;
        if (swap_pending !== e.sp) begin
          failures++;
          $display("FAIL swap_pending#%0d: got %b expected %b", e.id, swap_pending, e.sp);
        end
      end
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  // One idle cycle reading a front row, with the expected data queued for the monitor.
  task automatic rd(input logic [ROW_W-1:0] row, input logic [COLS-1:0] d, input logic sp);
    exp_t e;
    e.id   = chk_id;
    e.data = d;
    e.sp   = sp;
    chk_id++;
    exp_q.push_back(e);
    rd_row    = row;
    chk_valid = 1'b1;
    step();
    chk_valid = 1'b0;
  endtask

  task automatic wr(input logic [ROW_W-1:0] row, input logic [COLS-1:0] d);
    wr_en   = 1'b1;
    wr_row  = row;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic direct(input string name, input logic [COLS-1:0] got, input logic [COLS-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wvals [4];
    wvals[0] = 8'h11; wvals[1] = 8'h22; wvals[2] = 8'h44; wvals[3] = 8'h88;

    step();
    step();
    RST = 1'b0;
    step();

    // Reset state: front all zero, nothing pending.
    for (int r = 0; r < ROWS; r++) rd(ROW_W'(r), 8'h00, 1'b0);

    // Fill back, request swap, no frame boundary yet.
    for (int r = 0; r < ROWS; r++) wr(ROW_W'(r), wvals[r]);
    pulse_swap();
    for (int r = 0; r < ROWS; r++) rd(ROW_W'(r), 8'h00, 1'b1);
    pulse_frame();
    rd(2'd2, 8'h44, 1'b0);
    rd(2'd0, 8'h11, 1'b0);
    rd(2'd3, 8'h88, 1'b0);

    // swap_req with frame_start in IDLE only arms the swap.
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h00);
    swap_req    = 1'b1;
    frame_start = 1'b1;
    step();
    swap_req    = 1'b0;
    frame_start = 1'b0;
    rd(2'd0, 8'h11, 1'b1);
    pulse_frame();
    rd(2'd0, 8'hFF, 1'b0);
    rd(2'd1, 8'h00, 1'b0);

    // Shift-down-and-increment, with 0xFF wrapping to 0x00.
    mode    = 2'b01;
    auto_en = 1'b1;
    pulse_tick();
    pulse_frame();
    rd(2'd0, 8'h00, 1'b0);
    rd(2'd1, 8'hFF, 1'b0);
    rd(2'd2, 8'h00, 1'b0);
    pulse_tick();
    pulse_frame();
    rd(2'd0, 8'h01, 1'b0);
    rd(2'd1, 8'h00, 1'b0);
    rd(2'd2, 8'hFF, 1'b0);
    rd(2'd3, 8'h00, 1'b0);

    // Rotate, invert, and a held tick while the engine is disabled.
    wr(2'd0, 8'h81);
    pulse_swap();
    pulse_frame();
    rd(2'd0, 8'h81, 1'b0);
    mode = 2'b10;
    pulse_tick();
    pulse_frame();
    rd(2'd0, 8'h03, 1'b0);
    mode = 2'b11;
    pulse_tick();
    pulse_frame();
    rd(2'd0, 8'hFC, 1'b0);
    auto_en = 1'b0;
    pulse_tick();
    pulse_frame();
    rd(2'd0, 8'hFC, 1'b0);
    auto_en = 1'b1;
    pulse_frame();
    rd(2'd0, 8'h03, 1'b0);

    // Swap and pending tick at the same boundary: swap first, update one frame later.
    wr(2'd0, 8'h0F);
    pulse_tick();
    pulse_swap();
    pulse_frame();
    rd(2'd0, 8'h0F, 1'b0);
    pulse_frame();
    rd(2'd0, 8'hF0, 1'b0);

    // Last-wins double write, and a write in the swap cycle lands in the new front.
    wr(2'd3, 8'hAA);
    wr(2'd3, 8'hBB);
    pulse_swap();
    frame_start = 1'b1;
    wr_en       = 1'b1;
    wr_row      = 2'd1;
    wr_data     = 8'h5A;
    step();
    frame_start = 1'b0;
    wr_en       = 1'b0;
    rd(2'd1, 8'h5A, 1'b0);
    rd(2'd3, 8'hBB, 1'b0);

    // Asynchronous reset in the middle of a pending swap.
    pulse_swap();
    rd(2'd1, 8'h5A, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    direct("async_rst_rd_data", rd_data, 8'h00);
    direct("async_rst_swap_pending", {7'b0, swap_pending}, 8'h00);
    step();
    RST = 1'b0;
    step();
    rd(2'd1, 8'h00, 1'b0);
    rd(2'd3, 8'h00, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected reads never observed", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
